// File: rtl/debug_dump_tx_pkg.sv
// Shared debugger definitions: dump FSM states, source phases, word geometry
// and the command bytes also understood by the command receiver.
package debug_dump_tx_pkg;

   localparam int DATA_SZ_DEFAULT = 32;
   localparam int BYTES_PER_WORD  = DATA_SZ_DEFAULT / 8;

   localparam logic [7:0] LOAD_PROG_SIZE = 8'hFE;
   localparam logic [7:0] RUN            = 8'hF0;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LATCH,
      SEND,
      NEXT,
      DONE
   } dump_state_t;

   typedef enum logic [1:0] {
      PH_PC,
      PH_REG,
      PH_MEM
   } dump_phase_t;

   function automatic int bytes_per_word(input int data_sz);
      return data_sz / 8;
   endfunction

endpackage

// File: rtl/debug_dump_tx_word_serializer.sv
// Holds one captured word and shifts it out LSB-first into the UART TX FIFO,
// leaving an idle cycle after every write so strobes are never back to back.
module debug_dump_tx_word_serializer
   import debug_dump_tx_pkg::*;
#(
   parameter int DATA_SZ = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [DATA_SZ-1:0] i_word,
   input  logic               i_enable,
   input  logic               i_tx_full,
   output logic               o_wr,
   output logic [7:0]         o_data,
   output logic               o_last
);

   localparam int BPW   = bytes_per_word(DATA_SZ);
   localparam int CNT_W = $clog2(BPW + 1);

   logic [DATA_SZ-1:0] shift;
   logic [CNT_W-1:0]   byte_cnt;
   logic               gap;

   // A full FIFO blocks the strobe in the same cycle, so a refused byte stays put
   assign o_wr   = i_enable && !i_tx_full && !gap;
   assign o_data = shift[7:0];
   assign o_last = o_wr && (byte_cnt == CNT_W'(BPW - 1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shift    <= '0;
         byte_cnt <= '0;
         gap      <= 1'b0;
      end else if (i_load) begin
         shift    <= i_word;
         byte_cnt <= '0;
         gap      <= 1'b0;
      end else if (o_wr) begin
         shift    <= shift >> 8;
         byte_cnt <= byte_cnt + CNT_W'(1);
         gap      <= 1'b1;
      end else begin
         gap      <= 1'b0;
      end
   end

endmodule

// File: rtl/debug_dump_tx.sv
// Dump sequencer: once the pipeline halts, walks PC, registers and data memory,
// driving the debug address and feeding each selected word to the serializer.
module debug_dump_tx
   import debug_dump_tx_pkg::*;
#(
   parameter int DATA_SZ  = 32,
   parameter int W        = 5,
   parameter int NUM_REGS = 32,
   parameter int NUM_MEM  = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [DATA_SZ-1:0] i_pc,
   input  logic [DATA_SZ-1:0] i_register_data,
   input  logic [DATA_SZ-1:0] i_memory_data,
   input  logic               i_tx_full,
   output logic               o_wr_uart,
   output logic [7:0]         o_w_data,
   output logic [W-1:0]       o_addr,
   output logic               o_busy,
   output logic               o_done
);

   localparam logic [W-1:0] LAST_REG = W'(NUM_REGS - 1);
   localparam logic [W-1:0] LAST_MEM = W'(NUM_MEM - 1);

   dump_state_t        state, state_next;
   dump_phase_t        phase, phase_next;
   logic [W-1:0]       index, index_next;
   logic [DATA_SZ-1:0] src_word;
   logic               ser_last;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
         phase <= PH_PC;
         index <= '0;
      end else begin
         state <= state_next;
         phase <= phase_next;
         index <= index_next;
      end
   end

   always_comb begin
      src_word = i_pc;
      case (phase)
         PH_REG:  src_word = i_register_data;
         PH_MEM:  src_word = i_memory_data;
         default: src_word = i_pc;
      endcase
   end

   // Start is only looked at in IDLE and DONE, so toggling it mid-dump has no effect
   always_comb begin
      state_next = state;
      phase_next = phase;
      index_next = index;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_addr     = index;

      case (state)
         IDLE: begin
            o_addr     = '0;
            phase_next = PH_PC;
            index_next = '0;
            if (i_start) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            o_busy     = 1'b1;
            state_next = LATCH;
         end
         LATCH: begin
            o_busy     = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            o_busy = 1'b1;
            if (ser_last) begin
               state_next = NEXT;
            end
         end
         NEXT: begin
            o_busy     = 1'b1;
            state_next = SETUP;
            case (phase)
               PH_PC: begin
                  phase_next = PH_REG;
                  index_next = '0;
               end
               PH_REG: begin
                  if (index == LAST_REG) begin
                     phase_next = PH_MEM;
                     index_next = '0;
                  end else begin
                     index_next = index + W'(1);
                  end
               end
               PH_MEM: begin
                  if (index == LAST_MEM) begin
                     state_next = DONE;
                  end else begin
                     index_next = index + W'(1);
                  end
               end
               default: begin
                  phase_next = PH_PC;
                  index_next = '0;
               end
            endcase
         end
         DONE: begin
            o_addr = '0;
            o_done = 1'b1;
            if (!i_start) begin
               state_next = IDLE;
            end
         end
         default: begin
            o_addr     = '0;
            state_next = IDLE;
         end
      endcase
   end

   debug_dump_tx_word_serializer #(
      .DATA_SZ (DATA_SZ)
   ) u_serializer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (state == LATCH),
      .i_word    (src_word),
      .i_enable  (state == SEND),
      .i_tx_full (i_tx_full),
      .o_wr      (o_wr_uart),
      .o_data    (o_w_data),
      .o_last    (ser_last)
   );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Self-checking bench for debug_dump_tx: a byte-queue model of the full dump,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_debug_dump_tx;

   localparam int DATA_SZ  = 32;
   localparam int W        = 5;
   localparam int NUM_REGS = 32;
   localparam int NUM_MEM  = 32;
   localparam int TOTAL    = (1 + NUM_REGS + NUM_MEM) * DATA_SZ / 8;

   logic               i_clk = 1'b0;
   logic               i_reset = 1'b0;
   logic               i_start = 1'b0;
   logic               i_tx_full = 1'b0;
   logic [DATA_SZ-1:0] i_pc = '0;
   logic [DATA_SZ-1:0] i_register_data;
   logic [DATA_SZ-1:0] i_memory_data;
   logic               o_wr_uart;
   logic [7:0]         o_w_data;
   logic [W-1:0]       o_addr;
   logic               o_busy;
   logic               o_done;

   int         checks = 0;
   int         fails = 0;
   int         dump_bytes = 0;
   logic       prev_wr = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] seen[TOTAL];

   // Pipeline stand-in: register and memory contents are a function of the address
   assign i_register_data = 32'h1000_0000 + 32'(o_addr);
   assign i_memory_data   = 32'hA000_0000 + 32'(o_addr);

   always #5 i_clk = ~i_clk;

   debug_dump_tx #(
      .DATA_SZ  (DATA_SZ),
      .W        (W),
      .NUM_REGS (NUM_REGS),
      .NUM_MEM  (NUM_MEM)
   ) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_start         (i_start),
      .i_pc            (i_pc),
      .i_register_data (i_register_data),
      .i_memory_data   (i_memory_data),
      .i_tx_full       (i_tx_full),
      .o_wr_uart       (o_wr_uart),
      .o_w_data        (o_w_data),
      .o_addr          (o_addr),
      .o_busy          (o_busy),
      .o_done          (o_done)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected byte stream: PC, regs, mem; each word LSB first
   function automatic void build_dump(input logic [31:0] pc);
      logic [31:0] w;
      for (int k = 0; k < 1 + NUM_REGS + NUM_MEM; k++) begin
         if (k == 0)
            w = pc;
         else if (k <= NUM_REGS)
            w = 32'h1000_0000 + 32'(k - 1);
         else
            w = 32'hA000_0000 + 32'(k - 1 - NUM_REGS);
         for (int b = 0; b < DATA_SZ / 8; b++)
            exp_q.push_back(8'(w >> (8 * b)));
      end
   endfunction

   always @(negedge i_clk) begin
      if (o_wr_uart) begin
         check_output("strobe_back_to_back", 32'(prev_wr), 32'd0);
         check_output("strobe_while_full", 32'(i_tx_full), 32'd0);
         if (exp_q.size() == 0) begin
            check_output("unexpected_write", 32'(o_w_data), 32'hFFFF_FFFF);
         end else begin
            check_output("byte_value", 32'(o_w_data), 32'(exp_q.pop_front()));
         end
         if (dump_bytes < TOTAL)
            seen[dump_bytes] = o_w_data;
         dump_bytes++;
      end
      if (!o_busy)
         check_output("addr_when_not_busy", 32'(o_addr), 32'd0);
      prev_wr = o_wr_uart;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [31:0] pc);
      exp_q.delete();
      build_dump(pc);
      dump_bytes = 0;
      i_pc       = pc;
      i_start    = 1'b1;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c = 0;
      while (dump_bytes < n && c < budget) begin
         tick(1);
         c++;
      end
      check_output("wait_bytes_in_time", 32'(dump_bytes >= n), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!o_done && c < budget) begin
         tick(1);
         c++;
      end
      check_output("done_in_time", 32'(o_done), 32'd1);
   endtask

   task automatic wait_not_busy(input int budget);
      int c = 0;
      while (o_busy && c < budget) begin
         tick(1);
         c++;
      end
      check_output("idle_in_time", 32'(o_busy), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, "_wr"}, 32'(o_wr_uart), 32'd0);
      check_output({name, "_data"}, 32'(o_w_data), 32'd0);
      check_output({name, "_addr"}, 32'(o_addr), 32'd0);
      check_output({name, "_busy"}, 32'(o_busy), 32'd0);
      check_output({name, "_done"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      logic [7:0] lit_val [12];
      int         lit_idx [12];
      lit_val = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10,
                  8'h1F, 8'h00, 8'h00, 8'hA0};
      lit_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 256, 257, 258, 259};

      $display("[TB] reset state");
      i_reset = 1'b0;
      tick(3);
      check_all_zero("reset");
      i_reset = 1'b1;
      tick(2);

      $display("[TB] basic dump");
      apply_stimulus(32'h0000_0008);
      tick(2);
      check_output("first_strobe_not_early", 32'(o_wr_uart), 32'd0);
      tick(1);
      check_output("first_strobe_third_edge", 32'(o_wr_uart), 32'd1);
      wait_done(4000);
      check_output("basic_byte_count", 32'(dump_bytes), 32'(TOTAL));
      check_output("basic_queue_drained", 32'(exp_q.size()), 32'd0);
      check_output("basic_busy_low", 32'(o_busy), 32'd0);
      for (int i = 0; i < 12; i++)
         check_output($sformatf("basic_literal_byte%0d", lit_idx[i]),
                      32'(seen[lit_idx[i]]), 32'(lit_val[i]));
      i_start = 1'b0;
      tick(2);
      check_output("done_cleared", 32'(o_done), 32'd0);

      $display("[TB] back-pressure during byte 2 of reg[3]");
      apply_stimulus(32'h0000_0008);
      wait_bytes(18, 1000);
      i_tx_full = 1'b1;
      tick(20);
      check_output("bp_no_progress_while_full", 32'(dump_bytes), 32'd18);
      i_tx_full = 1'b0;
      tick(10);
      i_start = 1'b0;
      wait_not_busy(4000);
      check_output("bp_byte_count", 32'(dump_bytes), 32'(TOTAL));
      check_output("bp_queue_drained", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 12; i++)
         check_output($sformatf("bp_literal_byte%0d", lit_idx[i]),
                      32'(seen[lit_idx[i]]), 32'(lit_val[i]));
      tick(2);

      $display("[TB] re-arm");
      apply_stimulus(32'h0000_0008);
      wait_done(4000);
      tick(100);
      check_output("rearm_no_redump", 32'(dump_bytes), 32'(TOTAL));
      check_output("rearm_done_held", 32'(o_done), 32'd1);
      i_start = 1'b0;
      tick(1);
      check_output("rearm_done_dropped", 32'(o_done), 32'd0);
      apply_stimulus(32'h0000_0008);
      wait_done(4000);
      check_output("rearm_second_count", 32'(dump_bytes), 32'(TOTAL));
      check_output("rearm_second_drained", 32'(exp_q.size()), 32'd0);
      i_start = 1'b0;
      tick(2);

      $display("[TB] reset mid-dump");
      apply_stimulus(32'h0000_0008);
      wait_bytes(50, 1000);
      i_reset = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      i_start = 1'b0;
      tick(2);
      i_reset = 1'b1;
      tick(1);
      apply_stimulus(32'h1234_5678);
      wait_done(4000);
      check_output("restart_byte_count", 32'(dump_bytes), 32'(TOTAL));
      check_output("restart_first_pc_lsb", 32'(seen[0]), 32'h78);
      check_output("restart_pc_msb", 32'(seen[3]), 32'h12);
      i_start = 1'b0;
      tick(3);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
